// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types, constants and mode helpers for the OLED init sequencer
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_ADDR,
    ST_SEND_CTRL,
    ST_SEND_CMD,
    ST_SEND_DATA,
    ST_WAIT_ACK,
    ST_RETRY,
    ST_FINISH
  } state_t;

  localparam logic [1:0] MODE_INIT      = 2'd0;
  localparam logic [1:0] MODE_INIT_FILL = 2'd1;
  localparam logic [1:0] MODE_FILL      = 2'd2;
  localparam logic [1:0] MODE_OFF       = 2'd3;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;
  localparam logic [7:0] NOP       = 8'hE3;

  localparam int INIT_FIRST = 0;
  localparam int INIT_LAST  = 19;
  localparam int WIN_FIRST  = 20;
  localparam int WIN_LAST   = 25;
  localparam int OFF_IDX    = 26;

  function automatic int range_first(input logic [1:0] m);
    case (m)
      MODE_FILL: return WIN_FIRST;
      MODE_OFF:  return OFF_IDX;
      default:   return INIT_FIRST;
    endcase
  endfunction

  function automatic int range_last(input logic [1:0] m);
    case (m)
      MODE_INIT: return INIT_LAST;
      MODE_OFF:  return OFF_IDX;
      default:   return WIN_LAST;
    endcase
  endfunction

  function automatic logic has_fill(input logic [1:0] m);
    return (m == MODE_INIT_FILL) || (m == MODE_FILL);
  endfunction

endpackage

// File: rtl/oled_cmd_rom.sv
// rtl/oled_cmd_rom.sv - combinational SSD1306 command table, NOP beyond the defined entries
module oled_cmd_rom
  import oled_pkg::*;
#(
  parameter int CMD_DEPTH = 32,
  parameter int CMD_AW    = $clog2(CMD_DEPTH)
) (
  input  logic [CMD_AW-1:0] idx,
  output logic [7:0]        data
);

  always_comb begin
    data = NOP;
    if (int'(idx) < CMD_DEPTH) begin
      case (int'(idx))
        0:  data = 8'hA8;
        1:  data = 8'h3F;
        2:  data = 8'hD3;
        3:  data = 8'h00;
        4:  data = 8'h40;
        5:  data = 8'hA0;
        6:  data = 8'hC0;
        7:  data = 8'hDA;
        8:  data = 8'h02;
        9:  data = 8'h81;
        10: data = 8'h7F;
        11: data = 8'hA4;
        12: data = 8'hA6;
        13: data = 8'hD5;
        14: data = 8'h80;
        15: data = 8'h8D;
        16: data = 8'h14;
        17: data = 8'h20;
        18: data = 8'h00;
        19: data = 8'hAF;
        // addressing window: full column and page range
        20: data = 8'h21;
        21: data = 8'h00;
        22: data = 8'h7F;
        23: data = 8'h22;
        24: data = 8'h00;
        25: data = 8'h07;
        26: data = 8'hAE;
        default: data = NOP;
      endcase
    end
  end

endmodule

// File: rtl/oled_init_sequencer.sv
// rtl/oled_init_sequencer.sv - streams framed SSD1306 I2C write transactions with ACK check and retry
module oled_init_sequencer
  import oled_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = 7'h3C,
  parameter int         CMD_DEPTH    = 32,
  parameter int         FILL_BYTES   = 1024,
  parameter logic [7:0] FILL_PATTERN = 8'h00,
  parameter int         MAX_RETRY    = 3,
  parameter int         CMD_AW       = $clog2(CMD_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              tx_stop,
  input  logic              ack_valid,
  input  logic              ack_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        retry_count,
  output logic [CMD_AW-1:0] cmd_index
);

  localparam int         FW        = $clog2(FILL_BYTES + 1);
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  state_t            state_q, state_d, sent_q, sent_d;
  logic [1:0]        mode_q, mode_d, retry_q, retry_d;
  logic [CMD_AW-1:0] idx_q, idx_d, rom_idx;
  logic [FW-1:0]     fill_q, fill_d;
  logic              in_fill_q, in_fill_d;
  logic              tx_valid_q, tx_valid_d, tx_start_q, tx_start_d, tx_stop_q, tx_stop_d;
  logic [7:0]        tx_data_q, tx_data_d, rom_data;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  // ROM is addressed with the index the next command byte will carry
  assign rom_idx = (sent_q == ST_SEND_CMD) ? idx_q + CMD_AW'(1) : idx_q;

  oled_cmd_rom #(.CMD_DEPTH(CMD_DEPTH), .CMD_AW(CMD_AW)) u_rom (
    .idx  (rom_idx),
    .data (rom_data)
  );

  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    mode_d     = mode_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    in_fill_d  = in_fill_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    tx_stop_d  = tx_stop_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          idx_d      = CMD_AW'(range_first(mode));
          fill_d     = '0;
          retry_d    = '0;
          in_fill_d  = 1'b0;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          state_d    = ST_SEND_ADDR;
          tx_valid_d = 1'b1;
          tx_data_d  = ADDR_BYTE;
          tx_start_d = 1'b1;
          tx_stop_d  = 1'b0;
        end
      end
      ST_SEND_ADDR, ST_SEND_CTRL, ST_SEND_CMD, ST_SEND_DATA: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          sent_d     = state_q;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_valid && ack_nack) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_RETRY;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (ack_valid) begin
          tx_valid_d = 1'b1;
          tx_start_d = 1'b0;
          tx_stop_d  = 1'b0;
          case (sent_q)
            ST_SEND_ADDR: begin
              state_d   = ST_SEND_CTRL;
              tx_data_d = in_fill_q ? CTRL_DATA : CTRL_CMD;
            end
            ST_SEND_CTRL, ST_SEND_CMD: begin
              if (!in_fill_q && !(sent_q == ST_SEND_CMD && tx_stop_q)) begin
                state_d   = ST_SEND_CMD;
                idx_d     = rom_idx;
                tx_data_d = rom_data;
                tx_stop_d = (rom_idx == CMD_AW'(range_last(mode_q)));
              end else if (in_fill_q) begin
                state_d   = ST_SEND_DATA;
                fill_d    = '0;
                tx_data_d = FILL_PATTERN;
                tx_stop_d = (FILL_BYTES == 1);
              end else if (has_fill(mode_q)) begin
                state_d    = ST_SEND_ADDR;
                in_fill_d  = 1'b1;
                retry_d    = '0;
                tx_data_d  = ADDR_BYTE;
                tx_start_d = 1'b1;
              end else begin
                state_d    = ST_FINISH;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
              end
            end
            default: begin
              if (tx_stop_q) begin
                state_d    = ST_FINISH;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
              end else begin
                state_d   = ST_SEND_DATA;
                fill_d    = fill_q + FW'(1);
                tx_data_d = FILL_PATTERN;
                tx_stop_d = (fill_d == FW'(FILL_BYTES - 1));
              end
            end
          endcase
        end
      end
      ST_RETRY: begin
        idx_d      = CMD_AW'(range_first(mode_q));
        fill_d     = '0;
        state_d    = ST_SEND_ADDR;
        tx_valid_d = 1'b1;
        tx_data_d  = ADDR_BYTE;
        tx_start_d = 1'b1;
        tx_stop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sent_q     <= ST_IDLE;
      mode_q     <= '0;
      retry_q    <= '0;
      idx_q      <= '0;
      fill_q     <= '0;
      in_fill_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_stop_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sent_q     <= sent_d;
      mode_q     <= mode_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      fill_q     <= fill_d;
      in_fill_q  <= in_fill_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_stop_q  <= tx_stop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign tx_stop     = tx_stop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign retry_count = retry_q;
  assign cmd_index   = idx_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// tb/tb_oled_init_sequencer.sv - randomized directed bench with a transaction-level reference model
module tb_oled_init_sequencer;

  localparam int FILL = 4;
  localparam int RETRIES = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       tx_valid, tx_start, tx_stop, busy, done, error;
  logic       tx_ready = 1'b0;
  logic       ack_valid = 1'b0;
  logic       ack_nack = 1'b0;
  logic [7:0] tx_data;
  logic [1:0] retry_count;
  logic [4:0] cmd_index;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom_ref [0:26] = '{8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'hA0, 8'hC0, 8'hDA, 8'h02,
                                 8'h81, 8'h7F, 8'hA4, 8'hA6, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'h20,
                                 8'h00, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAE};
  logic [9:0] seq [$];

  oled_init_sequencer #(.SLAVE_ADDR(7'h3C), .CMD_DEPTH(32), .FILL_BYTES(FILL),
                        .FILL_PATTERN(8'h00), .MAX_RETRY(RETRIES)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_stop(tx_stop),
    .ack_valid(ack_valid), .ack_nack(ack_nack),
    .busy(busy), .done(done), .error(error),
    .retry_count(retry_count), .cmd_index(cmd_index)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream as {start, stop, data}, one transaction after another
  task automatic build_seq(input logic [1:0] m);
    int first, last;
    bit fill;
    case (m)
      2'd0:    begin first = 0;  last = 19; fill = 0; end
      2'd1:    begin first = 0;  last = 25; fill = 1; end
      2'd2:    begin first = 20; last = 25; fill = 1; end
      default: begin first = 26; last = 26; fill = 0; end
    endcase
    seq.delete();
    seq.push_back({2'b10, 8'h78});
    seq.push_back({2'b00, 8'h00});
    for (int i = first; i <= last; i++) seq.push_back({1'b0, i == last, rom_ref[i]});
    if (fill) begin
      seq.push_back({2'b10, 8'h78});
      seq.push_back({2'b00, 8'h40});
      for (int i = 0; i < FILL; i++) seq.push_back({1'b0, i == FILL - 1, 8'h00});
    end
  endtask

  task automatic run_seq(input logic [1:0] m, input int nack_at, input bit nack_all,
                         input bit rand_rdy, input bit noise, input int abort_at);
    int pos = 0, base = 0, retries = 0, xfers = 0, acks = 0, ack_cnt = 0, gap = 0;
    bit stalled = 0, fin_done = 0, fin_err = 0, ended = 0, aborted = 0, nack;
    logic [9:0] held = '0;
    build_seq(m);
    @(negedge CLK);
    start = 1'b1; mode = m; ack_valid = noise; ack_nack = 1'b0; tx_ready = 1'b0;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0; ack_valid = 1'b0;
    check("start_busy", {31'b0, busy}, 1);
    check("start_error_clear", {31'b0, error}, 0);
    check("start_retry", {30'b0, retry_count}, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ack_valid = 1'b0; ack_nack = 1'b0; start = 1'b0;
      if (fin_done || fin_err) begin
        check("end_done", {31'b0, done}, {31'b0, fin_done});
        check("end_busy", {31'b0, busy}, 0);
        check("end_error", {31'b0, error}, {31'b0, fin_err});
        check("end_valid", {31'b0, tx_valid}, 0);
        ended = 1;
        break;
      end
      if (xfers == abort_at && tx_valid) begin
        aborted = 1;
        break;
      end
      check("no_early_done", {31'b0, done}, 0);
      if (stalled)
        check("stall_hold", {21'b0, tx_valid, tx_start, tx_stop, tx_data}, {21'b0, 1'b1, held});
      if (gap == 2) begin
        check("retry_gap_idle", {31'b0, tx_valid}, 0);
        check("retry_count", {30'b0, retry_count}, retries);
        gap = 1;
      end else if (gap == 1) begin
        check("retry_restart", {22'b0, tx_valid, tx_start, tx_data}, {22'b0, 2'b11, 8'h78});
        gap = 0;
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          acks++;
          nack = nack_all || (acks == nack_at);
          ack_valid = 1'b1; ack_nack = nack;
          if (nack) begin
            if (retries < RETRIES) begin retries++; pos = base; gap = 2; end
            else fin_err = 1;
          end else begin
            pos++;
            if (seq[pos-1][8]) begin
              base = pos; retries = 0;
              if (pos == seq.size()) fin_done = 1;
            end
          end
        end
      end else if (noise && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; mode = 2'($urandom_range(0, 3));
        if (tx_valid) begin ack_valid = 1'b1; ack_nack = 1'($urandom_range(0, 1)); end
      end
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = tx_valid && !tx_ready;
      held = {tx_start, tx_stop, tx_data};
      if (tx_valid && tx_ready) begin
        check("byte", {22'b0, tx_start, tx_stop, tx_data},
              (pos < seq.size()) ? {22'b0, seq[pos]} : 32'hFFFF_FFFF);
        xfers++;
        ack_cnt = 2;
      end
      @(posedge CLK); @(negedge CLK);
    end
    ack_valid = 1'b0; start = 1'b0;
    check("sequence_bounded", {31'b0, ended || aborted}, 1);
  endtask

  task automatic post_idle(input bit noise, input bit exp_err);
    for (int i = 0; i < 4; i++) begin
      ack_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ack_nack = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      @(posedge CLK); @(negedge CLK);
      check("idle_done", {31'b0, done}, 0);
      check("idle_busy", {31'b0, busy}, 0);
      check("idle_valid", {31'b0, tx_valid}, 0);
      check("idle_error", {31'b0, error}, {31'b0, exp_err});
    end
    ack_valid = 1'b0; ack_nack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, {21'b0, tx_valid, tx_start, tx_stop, tx_data}, 0);
    check({tag, "_status"}, {29'b0, busy, done, error}, 0);
    check({tag, "_debug"}, {25'b0, retry_count, cmd_index}, 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    run_seq(2'd0, 0, 0, 0, 0, -1);
    post_idle(0, 0);
    run_seq(2'd2, 0, 0, 1, 0, -1);
    post_idle(0, 0);
    run_seq(2'd0, 5, 0, 0, 0, -1);
    post_idle(0, 0);
    run_seq(2'd0, 0, 1, 0, 0, -1);
    post_idle(1, 1);
    run_seq(2'd3, 0, 0, 1, 0, -1);
    post_idle(0, 0);

    run_seq(2'd1, 0, 0, 0, 0, 31);
    check("pre_reset_data_valid", {22'b0, tx_valid, tx_start, tx_data}, {22'b0, 2'b10, 8'h00});
    RST = 1'b1; tx_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check_reset_outputs("midreset");
    RST = 1'b0;
    run_seq(2'd3, 0, 0, 0, 0, -1);
    post_idle(0, 0);

    run_seq(2'd1, 0, 0, 1, 1, -1);
    post_idle(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_init_sequencer.md
Name: oled_init_sequencer

Overview:
- Parametrised successor to the static OLED setup table: a sequencer that streams complete SSD1306 I2C write transactions to the byte-level I2C master.
- Transactions are address byte, control byte, then command or data payload, with START/STOP framing, per-byte ACK checking and bounded retry on NACK.
- Four selectable modes: init, init+clear, clear only, display off.
- Sits between the top-level controller (start/mode) and the bit-level I2C engine.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit OLED address; the write address byte is {SLAVE_ADDR,1'b0} = 8'h78.
- CMD_DEPTH, 32, command ROM entries; ≥27. Index width CMD_AW = $clog2(CMD_DEPTH).
- FILL_BYTES, 1024, GDDRAM bytes written in a fill transaction; ≥1. Counter width $clog2(FILL_BYTES+1).
- FILL_PATTERN, 8'h00, data byte written during fill.
- MAX_RETRY, 3, NACK retries per transaction before error; ≥0.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- mode  in  2  0=init, 1=init+fill, 2=fill only, 3=display off; latched on accepted start
- tx_valid  out  1  byte available to I2C master
- tx_ready  in  1  master accepts byte (transfer = tx_valid & tx_ready)
- tx_data  out  8  byte to send
- tx_start  out  1  master issues START before this byte
- tx_stop  out  1  master issues STOP after this byte's ACK
- ack_valid  in  1  one-cycle pulse: ACK slot of last transferred byte complete
- ack_nack  in  1  qualified by ack_valid; 1 = NACK. Master then issues STOP itself.
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence finished without error
- error  out  1  sticky; cleared on next accepted start
- retry_count  out  2  retries used in the current transaction
- cmd_index  out  CMD_AW  current ROM index, for debug

Behaviour:
- Reset: all outputs 0; FSM in IDLE. A reset asserted mid-transfer takes effect on the next edge and drops tx_valid regardless of tx_ready.
- ROM contents (index:byte):
  - 0–19: A8 3F D3 00 40 A0 C0 DA 02 81 7F A4 A6 D5 80 8D 14 20 00 AF
  - 20–25: 21 00 7F 22 00 07 (addressing window)
  - 26: AE
  - others: E3 (NOP)
- Command range per mode:
  - mode 0: 0..19
  - mode 1: 0..25, then fill
  - mode 2: 20..25, then fill
  - mode 3: 26..26
- Command transaction: 78 (tx_start=1), 00, then range bytes; tx_stop=1 on the last range byte.
- Fill transaction: 78 (tx_start=1), 40, then FILL_BYTES×FILL_PATTERN; tx_stop=1 on the final data byte.
- FSM states: IDLE, SEND_ADDR, SEND_CTRL, SEND_CMD, SEND_DATA, WAIT_ACK, RETRY, FINISH.
- Timing:
  - start accepted at edge N → busy=1, tx_valid=1, tx_data=78 after edge N.
  - tx_data, tx_start and tx_stop stay stable while tx_valid & !tx_ready.
  - Transfer at edge T → tx_valid=0 from T; FSM enters WAIT_ACK.
  - ack_valid & !ack_nack at edge A → next byte valid after A. If the ACKed byte carried tx_stop, go instead to the next transaction (fill), or to FINISH.
- FINISH: done=1 for one cycle, busy=0 the same cycle, then IDLE. Each new transaction resets retry_count to 0.
- NACK handling:
  - If retry_count < MAX_RETRY: retry_count++, one cycle in RETRY (tx_valid=0), then restart the current transaction from byte 78. Command index returns to the range start; fill counter returns to 0.
  - Otherwise: error=1, busy=0, no done pulse, IDLE.
- Boundaries:
  - start while busy: ignored.
  - ack_valid outside WAIT_ACK: ignored.
  - tx_ready without tx_valid: no effect.
  - ack_valid in the same cycle as start in IDLE: start wins; the ack is ignored.
  - Fill counter ends exactly at FILL_BYTES; FILL_BYTES=1 gives one data byte with tx_stop set.

Decomposition:
- Package oled_pkg:
  - FSM state encoding
  - mode codes
  - control-byte constants: CTRL_CMD=8'h00, CTRL_DATA=8'h40
  - ROM range bounds: INIT_FIRST/INIT_LAST, WIN_FIRST/WIN_LAST, OFF_IDX
  - NOP=8'hE3
- Sub-module oled_cmd_rom: combinational index→byte case table, parametrised by CMD_DEPTH.

Test Plan:
- mode 0, tx_ready=1, ack_valid 2 cycles after each transfer, never NACK → 22 bytes 78 00 A8 … 00 AF. tx_start only on 78, tx_stop only on AF. One done pulse; error=0.
- mode 2, FILL_BYTES=4, tx_ready randomly low → tx_data held stable while stalled. Sequence 78 00 21 00 7F 22 00 07 (stop), then 78 40 00 00 00 00 (stop on last 00); done once.
- mode 0, NACK on the 5th byte once → retry_count=1, one idle cycle, restart at 78 00 A8; completes with done and error=0.
- NACK on every byte, MAX_RETRY=3 → 4 attempts of 78, then error=1, busy=0, no done. A subsequent start clears error.
- RST asserted while in SEND_DATA with tx_valid=1 → next cycle all outputs 0; a new start with mode 3 yields 78 00 AE then done.
- start pulsed while busy, and ack_valid pulsed in IDLE → no change to the byte sequence or outputs.
